// File: rtl/regfile_dump_reader.sv
// Debug/checkpoint reader: on start, walks the register file read port in ascending
// order and streams each captured value out over a valid/ready handshake.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int SKIP_R0  = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_R0 != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // NOTE: all state and outputs are registers updated with <= so every
    // process reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            idx       <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx     <= FIRST_IDX;
                        rd_addr <= FIRST_IDX;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    // rd_data is combinational off rd_addr, so it is valid this cycle.
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            rd_addr <= idx + 1'b1;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a 32-register instance exercised by dump sequences
// and a 4-register, SKIP_R0=0 instance driven from a cycle-by-cycle vector table.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 32-register instance with r0 skipped
    logic        start, out_ready;
    logic [4:0]  rd_addr, out_index;
    logic [31:0] rd_data, out_data;
    logic        out_valid, busy, done;
    logic [31:0] mem [32];
    assign rd_data = mem[rd_addr];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_R0(1)) dut (
        .clk(clk), .clrn(clrn), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .busy(busy), .done(done)
    );

    // 4-register instance starting at r0, with a 2-bit address so idx cannot wrap silently
    logic        start4, ready4;
    logic [1:0]  rd_addr4, index4;
    logic [31:0] rd_data4, data4;
    logic        valid4, busy4, done4;
    logic [31:0] mem4 [4];
    assign rd_data4 = mem4[rd_addr4];

    regfile_dump_reader #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(32), .SKIP_R0(0)) dut4 (
        .clk(clk), .clrn(clrn), .start(start4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .out_valid(valid4), .out_ready(ready4), .out_data(data4),
        .out_index(index4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic        start;
        logic        ready;
        logic        valid;
        logic [1:0]  index;
        logic [31:0] data;
        logic [1:0]  rd_addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic s, input logic r, input logic v, input logic [1:0] i,
                                input logic [1:0] ra, input logic b, input logic d);
        vec_t t;
        t.start   = s;
        t.ready   = r;
        t.valid   = v;
        t.index   = i;
        t.data    = 32'h0000_1110 + 32'(i);
        t.rd_addr = ra;
        t.busy    = b;
        t.done    = d;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full dump on the 32-register instance. Entered and left at a negedge with the DUT idle.
    task automatic dump(input int stall_word, input int stall_len, input bit extra_starts,
                        input bit live);
        logic [31:0] exp_data;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_read", 64'({out_valid, busy, done, rd_addr}), 64'({1'b0, 1'b1, 1'b0, 5'd1}));
        for (int w = 1; w <= 31; w++) begin
            if (live && w == 10) mem[10] = 32'hDEAD_BEEF;
            if (extra_starts && w == 7) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            exp_data = (live && w == 10) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(w);
            if (w == stall_word) begin
                out_ready = 1'b0;
                for (int c = 0; c < stall_len; c++) begin
                    check("stall_hold", 64'({out_valid, out_index, out_data, rd_addr}),
                          64'({1'b1, 5'(w), exp_data, 5'(w)}));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check($sformatf("word_%0d", w), 64'({out_valid, busy, done, out_index, out_data}),
                  64'({1'b1, 1'b1, 1'b0, 5'(w), exp_data}));
            if (extra_starts && w == 20) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (live && w == 3) mem[3] = 32'h0;
            if (w < 31) begin
                check("next_read", 64'({out_valid, busy, done, rd_addr}),
                      64'({1'b0, 1'b1, 1'b0, 5'(w + 1)}));
            end else begin
                check("done_pulse", 64'({out_valid, busy, done}), 64'({1'b0, 1'b0, 1'b1}));
                if (extra_starts) start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("back_idle", 64'({out_valid, busy, done}), 64'(3'b000));
        @(negedge clk);
        check("stay_idle", 64'({out_valid, busy, done}), 64'(3'b000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        clrn      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        start4    = 1'b0;
        ready4    = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) mem4[i] = 32'h0000_1110 + 32'(i);

        repeat (2) @(negedge clk);
        check("reset_state", 64'({rd_addr, out_data, out_index, out_valid, busy, done}), 64'h0);
        clrn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'({out_valid, busy, done}), 64'(3'b000));

        dump(0, 0, 1'b0, 1'b0);   // plain full dump
        dump(4, 5, 1'b0, 1'b0);   // backpressure on word 4
        dump(0, 0, 1'b1, 1'b0);   // start pulses while busy and in DONE
        dump(0, 0, 1'b0, 1'b1);   // live writes around READ edges

        // Reset in the middle of a stalled SEND
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_send", 64'({out_valid, busy, out_index}), 64'({1'b1, 1'b1, 5'd1}));
        #2 clrn = 1'b0;
        #1 check("async_reset", 64'({rd_addr, out_data, out_index, out_valid, busy, done}), 64'h0);
        @(negedge clk);
        check("held_reset", 64'({rd_addr, out_data, out_index, out_valid, busy, done}), 64'h0);
        clrn      = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_done_after_abort", 64'({out_valid, busy, done}), 64'(3'b000));
        end
        dump(0, 0, 1'b0, 1'b0);

        // Cycle table for the 4-register instance: check outputs, then drive inputs for the next edge
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            check($sformatf("vec_%0d", k),
                  64'({valid4, busy4, done4, rd_addr4, valid4 ? {index4, data4} : 34'h0}),
                  64'({vecs[k].valid, vecs[k].busy, vecs[k].done, vecs[k].rd_addr,
                       vecs[k].valid ? {vecs[k].index, vecs[k].data} : 34'h0}));
            start4 = vecs[k].start;
            ready4 = vecs[k].ready;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
